// File: rtl/uart_rx_fifo_if.sv
// Purpose: host/receiver-side signal bundle for the UART receive FIFO.
// Latency: n/a (wires only).
// Backpressure: i_rd_ready stalls the read side; the write side has no stall, only overflow.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                     i_wr_en;
  logic [DATA_W-1:0]        i_wr_data;
  logic [DATA_W-1:0]        o_rd_data;
  logic                     o_rd_valid;
  logic                     i_rd_ready;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_empty;
  logic                     o_full;
  logic                     o_afull;
  logic                     o_overflow;
  logic                     i_clr_ovf;

  // The FIFO itself
  modport slave (
    input  i_wr_en, i_wr_data, i_rd_ready, i_clr_ovf,
    output o_rd_data, o_rd_valid, o_count, o_empty, o_full, o_afull, o_overflow
  );

  // Receiver + host driving the FIFO
  modport master (
    output i_wr_en, i_wr_data, i_rd_ready, i_clr_ovf,
    input  o_rd_data, o_rd_valid, o_count, o_empty, o_full, o_afull, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular receive FIFO behind the UART receiver, first-word-fall-through read side.
// Latency: a byte strobed in at edge N is on o_rd_data with o_rd_valid=1 right after edge N.
// Backpressure: host stalls with i_rd_ready=0; a write into a full FIFO without a pop is dropped and flagged.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              ovf;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Status comes only from the registered count so it never follows input glitches.
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = ~empty & bus.i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
  assign push  = bus.i_wr_en & (~full | pop);
  assign drop  = bus.i_wr_en & full & ~pop;

  // Storage: written at the write pointer on every accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  // Pointers advance on push/pop and wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  // Sticky overflow: a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (bus.i_clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign bus.o_rd_data  = mem[rd_ptr];
  assign bus.o_rd_valid = ~empty;
  assign bus.o_count    = count;
  assign bus.o_empty    = empty;
  assign bus.o_full     = full;
  assign bus.o_afull    = (count >= CW'(AFULL_LVL));
  assign bus.o_overflow = ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: self-checking bench for uart_rx_fifo: vector table, corner sequences, random traffic vs. queue model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: host readiness is randomised in phases so full/overflow conditions are reached.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEP   = 16;
  localparam int AFULL = 12;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEP), .AFULL_LVL(AFULL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain byte queue plus sticky flag.
  logic [DW-1:0] mq[$];
  logic          m_ovf;

  typedef struct {
    logic          wr;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          clr;
    int            e_count;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_ovf;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int c;
    c = mq.size();
    chk("count", int'(bus.o_count), c);
    chk("empty", int'(bus.o_empty), int'(c == 0));
    chk("full", int'(bus.o_full), int'(c == DEP));
    chk("afull", int'(bus.o_afull), int'(c >= AFULL));
    chk("valid", int'(bus.o_rd_valid), int'(c != 0));
    chk("overflow", int'(bus.o_overflow), int'(m_ovf));
    if (c != 0) chk("rd_data", int'(bus.o_rd_data), int'(mq[0]));
  endtask

  // One clock with the given inputs; model advances by the spec rules, then all outputs compared.
  task automatic cycle(input logic wr, input logic [DW-1:0] dat, input logic rdy, input logic clr);
    bit was_full, do_pop;
    bus.i_wr_en   = wr;
    bus.i_wr_data = dat;
    bus.i_rd_ready = rdy;
    bus.i_clr_ovf = clr;
    @(posedge clk);
    #1;
    was_full = (mq.size() == DEP);
    do_pop   = (mq.size() != 0) && rdy;
    if (do_pop) void'(mq.pop_front());
    if (wr) begin
      if (!was_full || do_pop) mq.push_back(dat);
      else m_ovf = 1'b1;
    end
    if (!(wr && was_full && !do_pop) && clr) m_ovf = 1'b0;
    check_model();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEP; i++) cycle(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  task automatic drain_expect(input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      chk("drain_data", int'(bus.o_rd_data), int'(base + DW'(k)));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    vt[2] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
    vt[3] = '{1'b1, 8'hC3, 1'b0, 1'b0, 2, 1'b1, 8'h3C, 1'b0};
    vt[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 2, 1'b1, 8'hC3, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};

    reset = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_wr_data = '0;
    bus.i_rd_ready = 1'b0;
    bus.i_clr_ovf = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_empty", int'(bus.o_empty), 1);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_valid", int'(bus.o_rd_valid), 0);
    chk("rst_data", int'(bus.o_rd_data), 0);
    chk("rst_ovf", int'(bus.o_overflow), 0);
    chk("rst_full", int'(bus.o_full), 0);
    chk("rst_afull", int'(bus.o_afull), 0);

    // Vector table
    for (int v = 0; v < 9; v++) begin
      cycle(vt[v].wr, vt[v].dat, vt[v].rdy, vt[v].clr);
      chk($sformatf("vec%0d_count", v), int'(bus.o_count), vt[v].e_count);
      chk($sformatf("vec%0d_valid", v), int'(bus.o_rd_valid), int'(vt[v].e_valid));
      chk($sformatf("vec%0d_ovf", v), int'(bus.o_overflow), int'(vt[v].e_ovf));
      if (vt[v].e_valid) chk($sformatf("vec%0d_data", v), int'(bus.o_rd_data), int'(vt[v].e_data));
    end

    // Fill/drain three times to wrap both pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEP; i++) begin
        cycle(1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill_afull", int'(bus.o_afull), int'(i + 1 >= AFULL));
        chk("fill_full", int'(bus.o_full), int'(i + 1 == DEP));
      end
      drain_expect(8'h00, DEP);
      chk("drain_empty", int'(bus.o_empty), 1);
    end

    // Overflow: dropped byte never appears, flag sticks until cleared
    fill(8'h00);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", int'(bus.o_overflow), 1);
    chk("ovf_count", int'(bus.o_count), 16);
    drain_expect(8'h00, DEP);
    chk("ovf_held", int'(bus.o_overflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", int'(bus.o_overflow), 0);

    // Full + write + pop: both happen; then overflow beats clear
    fill(8'h10);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("fwp_count", int'(bus.o_count), 16);
    chk("fwp_ovf", int'(bus.o_overflow), 0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("set_wins", int'(bus.o_overflow), 1);
    drain_expect(8'h11, 15);
    chk("last_77", int'(bus.o_rd_data), 8'h77);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("fwp_empty", int'(bus.o_empty), 1);
    chk("fwp_clr", int'(bus.o_overflow), 0);

    // Asynchronous reset with 5 entries held
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + DW'(i), 1'b0, 1'b0);
    chk("pre_rst_count", int'(bus.o_count), 5);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", int'(bus.o_count), 0);
    chk("arst_empty", int'(bus.o_empty), 1);
    chk("arst_valid", int'(bus.o_rd_valid), 0);
    chk("arst_data", int'(bus.o_rd_data), 0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 8'h9C, 1'b0, 1'b0);
    chk("post_rst_data", int'(bus.o_rd_data), 8'h9C);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic in phases of varying write/read pressure
    for (int ph = 0; ph < 30; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
      rp = (ph % 5 == 0) ? 10 : (ph % 5 < 3) ? 50 : 90;
      for (int c = 0; c < 80; c++) begin
        cycle(($urandom_range(99) < wp) ? 1'b1 : 1'b0, DW'($urandom),
              ($urandom_range(99) < rp) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 8) ? 1'b1 : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
